sieve_marker: RTL and testbench
===============================

Name: sieve_marker

Overview:
- Upstream stage of the prime pipeline. It runs the square-root-bounded Sieve of Eratosthenes over BoolRam.
- It first clears BoolRam[0..max_prime] to 0 (0 = prime), then marks composites with 1.
- When marking is finished, it hands off to the populate stage with a `populating` / `done_populating` handshake and waits for that stage to finish.
- BoolRam: single-port, 1-bit, 1024 words. Synchronous read: q is valid the cycle after the address is presented.

Parameters:
- ADDR_W, 10, BoolRam address width and max_prime width.
- IDX_W, 11, width of the multiple counter j. Must be ≥ ADDR_W+1 so j+stride never wraps.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active-low
- start  in  1  1-cycle request to begin; ignored unless in IDLE
- max_prime  in  10  upper bound (inclusive); latched on accepted start
- bool_ram_q  in  1  BoolRam read data (1 = composite)
- bool_ram_addr  out  10  BoolRam address (read or write)
- bool_ram_data  out  1  BoolRam write data
- bool_ram_wren  out  1  BoolRam write enable
- populating  out  1  to populate stage; held high until done_populating
- done_populating  in  1  from populate stage
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse on completion

Behaviour:
- Reset values: bool_ram_addr=0, bool_ram_data=0, bool_ram_wren=0, populating=0, busy=0, done=0. State=IDLE; i=2; j=0; latched max m=0.
- All outputs are registered or decoded from state. No combinational path from inputs to outputs.
- IDLE:
  - On start: latch m=max_prime, addr counter=0, go to CLEAR.
  - If max_prime<2: instead go directly to DONE. No RAM writes, populating never asserted.
- CLEAR: wren=1, data=0, addr=counter. Counter increments each cycle. After writing addr=m, set i=2 and go to SQCHK. Takes m+1 cycles.
- SQCHK:
  - If i*i > m (20-bit product, unsigned): go to POP.
  - Otherwise drive addr=i (read) and go to RDWAIT.
- RDWAIT: single wait cycle for read latency. Go to TEST.
- TEST:
  - If bool_ram_q==0 (i is prime): j=i*i, go to MARK.
  - Otherwise: i=i+1, go to SQCHK.
- MARK:
  - If j ≤ m: wren=1, data=1, addr=j[9:0], then j=j+i. Stay in MARK.
  - If j > m: no write, i=i+1, go to SQCHK.
  - The comparison uses the full 11-bit j.
- POP: populating=1. When done_populating is sampled high, deassert populating next cycle and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Write/read exclusivity: wren is never asserted in SQCHK, RDWAIT or TEST.
- start while busy: ignored; no restart mid-run.
- reset_n low at any time: asynchronous return to reset values.
  - BoolRam contents are undefined afterwards. The next start re-clears them.
- The populate stage's index restarts only on its own reset. Supporting repeated runs without a global reset is out of scope.

Optional Feature:
- Macro: SIEVE_SKIP_EVEN_EN.
- When defined:
  - After i=2 is processed, i advances by 2 (3, 5, 7, ...).
  - For odd i, MARK uses stride 2*i (j=i*i, i*i+2i, ...), skipping even multiples already marked by i=2.
  - The stride register widens to IDX_W.
  - Final BoolRam contents are identical to the base mode; only cycle count and write count drop.
- When undefined: i increments by 1 and the stride is i.

Test Plan:
- max_prime=30, base mode:
  - BoolRam[2..30] zero exactly at 2,3,5,7,11,13,17,19,23,29.
  - Exactly 24 marking writes: 14 for i=2, 8 for i=3, 2 for i=5.
  - Loop exits at i=6.
  - populating rises once; after done_populating, done pulses once.
- Same run with SIEVE_SKIP_EVEN_EN: identical BoolRam contents; 19 marking writes (14+4+1).
- max_prime=1023: 172 zero entries in 2..1023. Last i tested is 31 (32*32=1024>1023). No write to an address above 1023 (j wrap check).
- max_prime=1 and max_prime=0: no wren, populating stays 0, done pulses within 2 cycles of start. max_prime=2: clear 0..2, no marking, POP immediate.
- Reset mid-run:
  - Assert reset_n low during MARK: all outputs are 0 asynchronously.
  - After release, start with max_prime=30 gives the same result as the first scenario.
- start pulsed during CLEAR and during POP: no effect on state, counters or latched max.

Source files
------------

// File: rtl/sieve_marker.sv
// sieve_marker: square-root-bounded Sieve of Eratosthenes over a 1-bit BoolRam, then hand-off to populate stage
// Ports: clk/reset_n (async, active-low); start + max_prime begin a run (ignored unless idle);
//   bool_ram_addr/data/wren/q drive the synchronous-read BoolRam (1 = composite);
//   populating/done_populating handshake with the populate stage; busy while not idle; done pulses once at the end.
// Optional: SIEVE_SKIP_EVEN_EN walks odd i only after i=2 and marks with stride 2*i.
module sieve_marker #(
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] max_prime,
  input  logic              bool_ram_q,
  output logic [ADDR_W-1:0] bool_ram_addr,
  output logic              bool_ram_data,
  output logic              bool_ram_wren,
  output logic              populating,
  input  logic              done_populating,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, CLEAR, SQCHK, RDWAIT, TEST, MARK, POP, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] m_q, m_d, i_q, i_d, i_nxt, addr_q, addr_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [2*ADDR_W-1:0] sq;
  logic data_q, data_d, wren_q, wren_d, pop_q, pop_d, done_q, done_d;
`ifdef SIEVE_SKIP_EVEN_EN
  logic [IDX_W-1:0] stride;
  assign i_nxt  = (i_q == ADDR_W'(2)) ? ADDR_W'(3) : i_q + ADDR_W'(2);
  assign stride = (i_q == ADDR_W'(2)) ? IDX_W'(i_q) : IDX_W'(i_q) << 1;
`else
  logic [ADDR_W-1:0] stride;
  assign i_nxt  = i_q + ADDR_W'(1);
  assign stride = i_q;
`endif
  assign sq            = (2*ADDR_W)'(i_q) * (2*ADDR_W)'(i_q);
  assign bool_ram_addr = addr_q;
  assign bool_ram_data = data_q;
  assign bool_ram_wren = wren_q;
  assign populating    = pop_q;
  assign done          = done_q;
  assign busy          = state_q != IDLE;
  // Outputs are registered, so each state computes the RAM command for the following cycle;
  // CLEAR therefore starts its first write on entry and MARK's writes trail its decisions by one cycle.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    i_d     = i_q;
    j_d     = j_q;
    addr_d  = addr_q;
    data_d  = 1'b0;
    wren_d  = 1'b0;
    pop_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        m_d     = max_prime;
        addr_d  = '0;
        state_d = (max_prime < ADDR_W'(2)) ? DONE : CLEAR;
        done_d  = max_prime < ADDR_W'(2);
        wren_d  = max_prime >= ADDR_W'(2);
      end
      CLEAR: if (addr_q == m_q) begin
        state_d = SQCHK;
        i_d     = ADDR_W'(2);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        wren_d = 1'b1;
      end
      SQCHK: if (sq > (2*ADDR_W)'(m_q)) begin
        state_d = POP;
        pop_d   = 1'b1;
      end else begin
        addr_d  = i_q;
        state_d = RDWAIT;
      end
      RDWAIT: state_d = TEST;
      TEST: if (!bool_ram_q) begin
        j_d     = sq[IDX_W-1:0];
        state_d = MARK;
      end else begin
        i_d     = i_nxt;
        state_d = SQCHK;
      end
      // j is compared at full width so a step past the top of the RAM can never alias back in range.
      MARK: if (j_q <= IDX_W'(m_q)) begin
        wren_d = 1'b1;
        data_d = 1'b1;
        addr_d = j_q[ADDR_W-1:0];
        j_d    = j_q + IDX_W'(stride);
      end else begin
        i_d     = i_nxt;
        state_d = SQCHK;
      end
      POP: begin
        state_d = done_populating ? DONE : POP;
        done_d  = done_populating;
        pop_d   = !done_populating;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      i_q     <= ADDR_W'(2);
      j_q     <= '0;
      addr_q  <= '0;
      data_q  <= 1'b0;
      wren_q  <= 1'b0;
      pop_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      i_q     <= i_d;
      j_q     <= j_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      pop_q   <= pop_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_sieve_marker.sv
// tb_sieve_marker: scoreboard bench for sieve_marker with a BoolRam model and a populate-stage responder
module tb_sieve_marker;
`ifdef SIEVE_SKIP_EVEN_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk = 0, reset_n = 0, start = 0, bool_ram_q = 0, done_populating = 0;
  logic [9:0] max_prime = '0, bool_ram_addr;
  logic bool_ram_data, bool_ram_wren, populating, busy, done;
  logic mem [1024];
  logic [11:0] exp_q [$];
  logic [11:0] e;
  logic pop_prev = 0;
  int n_cmp = 0, n_bad = 0, marks = 0, pop_rises = 0, dones = 0;
  always #5 clk = ~clk;
  sieve_marker dut (
    .clk(clk), .reset_n(reset_n), .start(start), .max_prime(max_prime),
    .bool_ram_q(bool_ram_q), .bool_ram_addr(bool_ram_addr), .bool_ram_data(bool_ram_data),
    .bool_ram_wren(bool_ram_wren), .populating(populating), .done_populating(done_populating),
    .busy(busy), .done(done)
  );
  always @(posedge clk) begin
    if (bool_ram_wren) mem[bool_ram_addr] <= bool_ram_data;
    bool_ram_q <= mem[bool_ram_addr];
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (reset_n) begin
    if (bool_ram_wren) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hfff;
      check("wr", 32'({bool_ram_data, bool_ram_addr}), 32'(e));
      marks += int'(bool_ram_data);
    end
    if (populating && !pop_prev) pop_rises++;
    pop_prev = populating;
    dones += int'(done);
  end
  function automatic bit is_prime(input int n);
    if (n < 2) return 0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 0;
    return 1;
  endfunction
  task automatic load_model(input int m);
    int i, st;
    exp_q.delete();
    if (m < 2) return;
    for (int k = 0; k <= m; k++) exp_q.push_back(12'({1'b0, 10'(k)}));
    i = 2;
    while (i * i <= m) begin
      if (is_prime(i)) begin
        st = (SKIP && i != 2) ? 2 * i : i;
        for (int j = i * i; j <= m; j += st) exp_q.push_back(12'({1'b1, 10'(j)}));
      end
      i = SKIP ? ((i == 2) ? 3 : i + 2) : i + 1;
    end
  endtask
  task automatic run(input int m, input bit poke, input int exp_primes, input int exp_marks);
    int pcnt = 0, cyc, bad = 0, zeros = 0;
    load_model(m);
    marks = 0;
    pop_rises = 0;
    dones = 0;
    @(negedge clk);
    max_prime = 10'(m);
    start = 1;
    @(negedge clk);
    start = 0;
    max_prime = 10'd7;
    for (cyc = 0; cyc < 20000; cyc++) begin
      if (done) break;
      start = poke && (cyc == 3 || (populating && pcnt == 1));
      max_prime = start ? 10'd100 : 10'd7;
      if (populating) pcnt++;
      done_populating = populating && pcnt == 3;
      @(negedge clk);
    end
    start = 0;
    done_populating = 0;
    check("done_seen", 32'(done), 1);
    if (m < 2) check("done_lat", 32'(cyc <= 1), 1);
    check("pop_rises", 32'(pop_rises), 32'(m >= 2));
    check("pop_cycles", 32'(pcnt), (m >= 2) ? 3 : 0);
    @(negedge clk);
    #1;
    check("done_pulse", 32'(dones), 1);
    check("idle", 32'(busy), 0);
    check("left", 32'(exp_q.size()), 0);
    if (exp_marks >= 0) check("marks", 32'(marks), 32'(exp_marks));
    if (m >= 2) begin
      for (int k = 2; k <= m; k++) begin
        zeros += int'(mem[k] === 1'b0);
        bad += int'(mem[k] !== !is_prime(k));
      end
      check("ram", 32'(bad), 0);
      check("primes", 32'(zeros), 32'(exp_primes));
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1;
    #1 check("rst_outs", 32'({bool_ram_addr, bool_ram_data, bool_ram_wren, populating, busy, done}), 0);
    run(30, 0, 10, SKIP ? 19 : 24);
    run(30, 1, 10, SKIP ? 19 : 24);
    run(2, 0, 1, 0);
    run(1, 0, 0, 0);
    run(0, 0, 0, 0);
    run(1023, 0, 172, -1);
    load_model(30);
    marks = 0;
    @(negedge clk);
    max_prime = 10'd30;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 500 && marks == 0; c++) begin
      @(negedge clk);
      #1;
    end
    check("reach_mark", 32'(marks > 0), 1);
    #1 reset_n = 0;
    #1 check("async_rst", 32'({bool_ram_addr, bool_ram_data, bool_ram_wren, populating, busy, done}), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1;
    run(30, 0, 10, SKIP ? 19 : 24);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
